jacobi_sweep_scheduler: RTL and testbench
=========================================

JACOBI_SWEEP_SCHEDULER -- requirements
Module: jacobi_sweep_scheduler

Interface
REQ-001 SHALL have parameter N, default 4: matrix dimension, range 3..16.
REQ-002 SHALL have parameter MAX_SWEEPS, default 8: sweep limit, range 1..255.
REQ-003 SHALL have parameter ADDR_W, default JACOBI_ADDR_WIDTH: element address width; requires N*N <= 2**ADDR_W.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk, input, 1: sole clock; all logic on the rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-007 SHALL have port start_i, input, 1: single-cycle request to begin a decomposition.
REQ-008 SHALL have port stop_i, input, 1: convergence request; terminates the run after the current sweep.
REQ-009 SHALL have port pair_vld_o, output, 1: rotation pair valid.
REQ-010 SHALL have port pair_rdy_i, input, 1: controller accepts the pair.
REQ-011 SHALL have port pair_p_o, output, $clog2(N): row index p.
REQ-012 SHALL have port pair_q_o, output, $clog2(N): column index q, with q > p.
REQ-013 SHALL have port addr_pp_o, output, ADDR_W: row-major address of A[p][p] (p*N+p).
REQ-014 SHALL have port addr_pq_o, output, ADDR_W: address of A[p][q] (p*N+q).
REQ-015 SHALL have port addr_qq_o, output, ADDR_W: address of A[q][q] (q*N+q).
REQ-016 SHALL have port rot_done_i, input, 1: single-cycle pulse; the accepted pair's rotation is fully written back.
REQ-017 SHALL have port busy_o, output, 1: high from the start-accept cycle until DONE completes.
REQ-018 SHALL have port sweep_cnt_o, output, 8: count of completed sweeps in the current run.
REQ-019 SHALL have port done_o, output, 1: one-cycle end-of-run pulse.

Function
REQ-020 SHALL implement a four-state FSM: IDLE, ISSUE, WAIT, DONE.
REQ-021 SHALL transition IDLE->ISSUE on start_i; set p=0, q=1, sweep count=0, stop flag=0; assert busy_o the same cycle the start is accepted (registered, visible next cycle).
REQ-022 SHALL ignore start_i outside IDLE.
REQ-023 SHALL, in ISSUE, drive pair_vld_o=1 and transition to WAIT on the cycle pair_vld_o&&pair_rdy_i.
REQ-024 SHALL hold pair_p_o, pair_q_o and all addr_*_o stable while pair_vld_o=1 and pair_rdy_i=0.
REQ-025 SHALL register the addr_*_o outputs; they are valid whenever pair_vld_o=1, with no multiplier in the output path (use an incrementally maintained row base).
REQ-026 SHALL keep pair_vld_o=0 in IDLE, WAIT and DONE; at most one pair is outstanding at any time.
REQ-027 SHALL, in WAIT, on rot_done_i advance cyclic-by-row: q<N-1 -> q+1; else p<N-2 -> p+1, q=p+2; else end of sweep.
REQ-028 SHALL, at end of sweep, increment sweep_cnt_o, then go to DONE if the new count equals MAX_SWEEPS or the stop flag is set; otherwise go to ISSUE with p=0, q=1.
REQ-029 SHALL issue N(N-1)/2 pairs per sweep; the first pair of a new sweep is valid 1 cycle after the last rot_done_i.
REQ-030 SHALL set the stop flag sticky on stop_i during ISSUE/WAIT; stop_i in the same cycle as the final rot_done_i of a sweep terminates after that sweep.
REQ-031 SHALL ignore stop_i in IDLE and DONE.
REQ-032 SHALL ignore rot_done_i outside WAIT.
REQ-033 SHALL, in DONE, assert done_o for exactly one cycle, deassert busy_o, and return to IDLE.
REQ-034 SHALL hold sweep_cnt_o at its final value until the next start.
REQ-035 SHALL treat start_i in the DONE cycle as ignored.
REQ-036 SHALL saturate sweep_cnt_o at 255.

Reset
REQ-037 SHALL, on rst, enter IDLE and clear pair_vld_o, busy_o, done_o, sweep_cnt_o, p, q and addr_*_o to 0, and clear the stop flag.
REQ-038 SHALL give rst priority over all inputs, including mid-WAIT; no done_o is generated for an aborted run.

Verification
REQ-039 SHALL pass: N=4, start, rdy always 1, rot_done_i 3 cycles after each accept, MAX_SWEEPS=2 -> pairs (0,1)(0,2)(0,3)(1,2)(1,3)(2,3) twice; addr_pq sequence 1,2,3,6,7,11; sweep_cnt 1 then 2; one done_o.
REQ-040 SHALL pass: pair_rdy_i low for 5 cycles on pair (1,2) -> outputs stable at p=1, q=2, addr_pp=5, addr_pq=6, addr_qq=10; single acceptance.
REQ-041 SHALL pass: stop_i pulse during pair (0,2) of sweep 1 -> sweep completes all 6 pairs; done_o with sweep_cnt_o=1.
REQ-042 SHALL pass: stray rot_done_i in ISSUE and IDLE, and start_i while busy -> no pair advance, no restart.
REQ-043 SHALL pass: rst asserted in WAIT of pair (1,3) -> next cycle all outputs 0, IDLE; a new start yields (0,1) with sweep_cnt_o=0.

Source files
------------

// File: rtl/jacobi_sweep_scheduler.sv
// Cyclic-by-row Jacobi rotation-pair scheduler: issues (p,q) pairs with their
// row-major element addresses, one pair outstanding, for up to MAX_SWEEPS sweeps.
`ifndef JACOBI_ADDR_WIDTH
`define JACOBI_ADDR_WIDTH 8
`endif

module jacobi_sweep_scheduler #(
    parameter int N          = 4,
    parameter int MAX_SWEEPS = 8,
    parameter int ADDR_W     = `JACOBI_ADDR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic                   stop_i,
    output logic                   pair_vld_o,
    input  logic                   pair_rdy_i,
    output logic [$clog2(N)-1:0]   pair_p_o,
    output logic [$clog2(N)-1:0]   pair_q_o,
    output logic [ADDR_W-1:0]      addr_pp_o,
    output logic [ADDR_W-1:0]      addr_pq_o,
    output logic [ADDR_W-1:0]      addr_qq_o,
    input  logic                   rot_done_i,
    output logic                   busy_o,
    output logic [7:0]             sweep_cnt_o,
    output logic                   done_o,
    output logic [1:0]             fsm_state
);

    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0]  LAST_Q  = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0]  LAST_P  = IDX_W'(N - 2);
    localparam logic [IDX_W-1:0]  ONE_I   = IDX_W'(1);
    localparam logic [IDX_W-1:0]  TWO_I   = IDX_W'(2);
    localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] NP1     = ADDR_W'(N + 1);
    localparam logic [ADDR_W-1:0] NP2     = ADDR_W'(N + 2);
    localparam logic [ADDR_W-1:0] N2P2    = ADDR_W'(2 * N + 2);
    localparam logic [7:0]        MAX_CNT = 8'(MAX_SWEEPS);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  p, q;
    logic [ADDR_W-1:0] a_pp, a_pq, a_qq;
    logic [7:0]        sweep_cnt, cnt_inc;
    logic              stop_flag, busy;
    logic              rot, last_in_row, last_row, sweep_end, finish;

    always_comb begin
        rot         = (state == WAIT) && rot_done_i;
        last_in_row = (q == LAST_Q);
        last_row    = (p == LAST_P);
        sweep_end   = last_in_row && last_row;
        cnt_inc     = (sweep_cnt == 8'hFF) ? sweep_cnt : sweep_cnt + 8'd1;
        // stop_i arriving with the sweep's final rot_done_i still ends this sweep
        finish      = (cnt_inc == MAX_CNT) || stop_flag || stop_i;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i) state_nxt = ISSUE;
            ISSUE:   if (pair_rdy_i) state_nxt = WAIT;
            WAIT:    if (rot_done_i) state_nxt = (sweep_end && finish) ? DONE : ISSUE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Addresses advance by fixed strides from the current diagonal, so the
    // output path never needs p*N.
    always_ff @(posedge clk) begin
        if (rst) begin
            p         <= '0;
            q         <= '0;
            a_pp      <= '0;
            a_pq      <= '0;
            a_qq      <= '0;
            sweep_cnt <= '0;
            stop_flag <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        p         <= '0;
                        q         <= ONE_I;
                        a_pp      <= '0;
                        a_pq      <= ONE_A;
                        a_qq      <= NP1;
                        sweep_cnt <= '0;
                        stop_flag <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                ISSUE, WAIT: begin
                    if (stop_i) stop_flag <= 1'b1;
                    if (rot) begin
                        if (!last_in_row) begin
                            q    <= q + ONE_I;
                            a_pq <= a_pq + ONE_A;
                            a_qq <= a_qq + NP1;
                        end else if (!last_row) begin
                            p    <= p + ONE_I;
                            q    <= p + TWO_I;
                            a_pp <= a_pp + NP1;
                            a_pq <= a_pp + NP2;
                            a_qq <= a_pp + N2P2;
                        end else begin
                            sweep_cnt <= cnt_inc;
                            p         <= '0;
                            q         <= ONE_I;
                            a_pp      <= '0;
                            a_pq      <= ONE_A;
                            a_qq      <= NP1;
                        end
                    end
                end
                DONE: busy <= 1'b0;
                default: ;
            endcase
        end
    end

    always_comb begin
        pair_vld_o  = (state == ISSUE);
        done_o      = (state == DONE);
        busy_o      = busy;
        pair_p_o    = p;
        pair_q_o    = q;
        addr_pp_o   = a_pp;
        addr_pq_o   = a_pq;
        addr_qq_o   = a_qq;
        sweep_cnt_o = sweep_cnt;
        fsm_state   = state;
    end

endmodule

// File: tb/tb_jacobi_sweep_scheduler.sv
// Self-checking bench: a responder drives the pair handshake and rotation
// completions while a queue of expected (p,q,addresses) tuples checks each issued pair.
module tb_jacobi_sweep_scheduler;

    localparam int N          = 4;
    localparam int MAX_SWEEPS = 2;
    localparam int ADDR_W     = 8;
    localparam int IDX_W      = $clog2(N);
    localparam int PAIRS      = N * (N - 1) / 2;
    localparam int EXP_W      = 2 * IDX_W + 3 * ADDR_W;

    logic              clk = 1'b0;
    logic              rst, start_i, stop_i, pair_rdy_i, rot_done_i;
    logic              pair_vld_o, busy_o, done_o;
    logic [IDX_W-1:0]  pair_p_o, pair_q_o;
    logic [ADDR_W-1:0] addr_pp_o, addr_pq_o, addr_qq_o;
    logic [7:0]        sweep_cnt_o;
    logic [1:0]        fsm_state;

    logic [EXP_W-1:0]  exp_q[$];
    int                vectors = 0;
    int                miscompares = 0;

    jacobi_sweep_scheduler #(.N(N), .MAX_SWEEPS(MAX_SWEEPS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i),
        .pair_vld_o(pair_vld_o), .pair_rdy_i(pair_rdy_i),
        .pair_p_o(pair_p_o), .pair_q_o(pair_q_o),
        .addr_pp_o(addr_pp_o), .addr_pq_o(addr_pq_o), .addr_qq_o(addr_qq_o),
        .rot_done_i(rot_done_i), .busy_o(busy_o), .sweep_cnt_o(sweep_cnt_o),
        .done_o(done_o), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    function automatic logic [EXP_W-1:0] pair_entry(input int p, input int q);
        return {IDX_W'(p), IDX_W'(q), ADDR_W'(p * N + p), ADDR_W'(p * N + q), ADDR_W'(q * N + q)};
    endfunction

    function automatic void load_model(input int sweeps);
        exp_q.delete();
        for (int s = 0; s < sweeps; s++)
            for (int p = 0; p < N - 1; p++)
                for (int q = p + 1; q < N; q++)
                    exp_q.push_back(pair_entry(p, q));
    endfunction

    // rdy_mode: 0 always ready, 1 random, 2 hold pair (1,2) for 5 cycles.
    // stop_at/abort_at: accepted-pair ordinal (1-based) at which stop_i or rst fires; 0 = never.
    task automatic do_run(input int rdy_mode, input int stop_at, input int abort_at,
                          input int lat_fixed, input bit stray, input bit start_in_done);
        int exp_sweeps, accepted, rotated, stall, budget, lat;
        bit rdy, fin;
        exp_sweeps = MAX_SWEEPS;
        if (stop_at > 0 && (stop_at + PAIRS - 1) / PAIRS < MAX_SWEEPS)
            exp_sweeps = (stop_at + PAIRS - 1) / PAIRS;
        load_model(exp_sweeps);
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        vectors++;
        if (busy_o !== 1'b1 || sweep_cnt_o !== 8'd0) begin
            miscompares++;
            $display("FAIL start_accept: busy=%b cnt=%0d, required busy=1 cnt=0", busy_o, sweep_cnt_o);
        end
        accepted = 0; rotated = 0; stall = 0; fin = 1'b0; budget = 2000;
        while (!fin) begin
            budget--;
            if (budget <= 0) begin
                miscompares++;
                $display("FAIL timeout: run did not reach done_o within cycle budget");
                fin = 1'b1;
            end else if (done_o === 1'b1) begin
                vectors++;
                if (sweep_cnt_o !== 8'(exp_sweeps) || exp_q.size() != 0) begin
                    miscompares++;
                    $display("FAIL done_state: cnt=%0d pending=%0d, required cnt=%0d pending=0",
                             sweep_cnt_o, exp_q.size(), exp_sweeps);
                end
                start_i = start_in_done;
                @(negedge clk); start_i = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    vectors++;
                    if (done_o !== 1'b0 || busy_o !== 1'b0 || pair_vld_o !== 1'b0 ||
                        sweep_cnt_o !== 8'(exp_sweeps)) begin
                        miscompares++;
                        $display("FAIL after_done: done=%b busy=%b vld=%b cnt=%0d, required 0 0 0 %0d",
                                 done_o, busy_o, pair_vld_o, sweep_cnt_o, exp_sweeps);
                    end
                    rot_done_i = stray ? 1'($urandom_range(0, 1)) : 1'b0;
                    @(negedge clk); rot_done_i = 1'b0;
                end
                fin = 1'b1;
            end else if (pair_vld_o === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL extra_pair: p=%0d q=%0d issued, required none", pair_p_o, pair_q_o);
                end else if ({pair_p_o, pair_q_o, addr_pp_o, addr_pq_o, addr_qq_o} !== exp_q[0] ||
                             sweep_cnt_o !== 8'(rotated / PAIRS) || busy_o !== 1'b1) begin
                    miscompares++;
                    $display("FAIL pair: got p=%0d q=%0d pp=%0d pq=%0d qq=%0d cnt=%0d busy=%b, required {p,q,pp,pq,qq}=%h cnt=%0d busy=1",
                             pair_p_o, pair_q_o, addr_pp_o, addr_pq_o, addr_qq_o, sweep_cnt_o, busy_o,
                             exp_q[0], rotated / PAIRS);
                end
                rdy = 1'b1;
                if (rdy_mode == 1) rdy = 1'($urandom_range(0, 1));
                if (rdy_mode == 2 && exp_q.size() != 0 && exp_q[0] == pair_entry(1, 2) && stall < 5) begin
                    rdy = 1'b0;
                    stall++;
                end
                pair_rdy_i = rdy;
                if (!rdy && stray) begin
                    rot_done_i = 1'($urandom_range(0, 1));
                    start_i    = 1'($urandom_range(0, 1));
                end
                @(negedge clk);
                pair_rdy_i = 1'b0; rot_done_i = 1'b0; start_i = 1'b0;
                if (rdy) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    accepted++;
                    if (accepted == abort_at) begin
                        rst = 1'b1; rot_done_i = 1'b1;
                        @(negedge clk); rst = 1'b0; rot_done_i = 1'b0;
                        vectors++;
                        if ({pair_vld_o, busy_o, done_o, sweep_cnt_o, pair_p_o, pair_q_o,
                             addr_pp_o, addr_pq_o, addr_qq_o} !== '0) begin
                            miscompares++;
                            $display("FAIL abort_clear: vld=%b busy=%b done=%b cnt=%0d p=%0d q=%0d pp=%0d pq=%0d qq=%0d, required all 0",
                                     pair_vld_o, busy_o, done_o, sweep_cnt_o, pair_p_o, pair_q_o,
                                     addr_pp_o, addr_pq_o, addr_qq_o);
                        end
                        for (int i = 0; i < 3; i++) begin
                            @(negedge clk);
                            vectors++;
                            if (done_o !== 1'b0 || busy_o !== 1'b0 || pair_vld_o !== 1'b0) begin
                                miscompares++;
                                $display("FAIL abort_quiet: done=%b busy=%b vld=%b, required 0 0 0",
                                         done_o, busy_o, pair_vld_o);
                            end
                        end
                        exp_q.delete();
                        fin = 1'b1;
                    end else begin
                        lat = (lat_fixed >= 0) ? lat_fixed : $urandom_range(0, 3);
                        for (int i = 0; i <= lat; i++) begin
                            vectors++;
                            if (pair_vld_o !== 1'b0 || busy_o !== 1'b1) begin
                                miscompares++;
                                $display("FAIL wait_idle: vld=%b busy=%b, required vld=0 busy=1", pair_vld_o, busy_o);
                            end
                            if (i == lat) break;
                            start_i = stray ? 1'($urandom_range(0, 1)) : 1'b0;
                            @(negedge clk); start_i = 1'b0;
                        end
                        rot_done_i = 1'b1;
                        stop_i     = (accepted == stop_at);
                        @(negedge clk); rot_done_i = 1'b0; stop_i = 1'b0;
                        rotated++;
                    end
                end
            end else begin
                miscompares++;
                $display("FAIL progress: neither pair_vld_o nor done_o set mid-run (busy=%b)", busy_o);
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b1; stop_i = 1'b0; pair_rdy_i = 1'b1; rot_done_i = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({pair_vld_o, busy_o, done_o, sweep_cnt_o, pair_p_o, pair_q_o,
             addr_pp_o, addr_pq_o, addr_qq_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: vld=%b busy=%b done=%b cnt=%0d p=%0d q=%0d pp=%0d pq=%0d qq=%0d, required all 0",
                     pair_vld_o, busy_o, done_o, sweep_cnt_o, pair_p_o, pair_q_o, addr_pp_o, addr_pq_o, addr_qq_o);
        end
        rst = 1'b0; start_i = 1'b0; pair_rdy_i = 1'b0; rot_done_i = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy_o !== 1'b0 || pair_vld_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_priority: busy=%b vld=%b, required 0 0", busy_o, pair_vld_o);
        end
    endtask

    task automatic test_main();          do_run(0, 0, 0, 3, 1'b0, 1'b0);      endtask
    task automatic test_stall();         do_run(2, 0, 0, -1, 1'b0, 1'b0);     endtask
    task automatic test_stop();          do_run(0, 2, 0, -1, 1'b0, 1'b0);     endtask
    task automatic test_stop_last();     do_run(1, PAIRS, 0, -1, 1'b0, 1'b0); endtask
    task automatic test_stray();         do_run(1, 0, 0, -1, 1'b1, 1'b1);     endtask

    task automatic test_reset_mid_wait();
        do_run(0, 0, 5, 2, 1'b0, 1'b0);
        do_run(0, 0, 0, 1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 4; r++)
            do_run(1, $urandom_range(0, 2 * PAIRS), 0, -1, 1'b1, 1'($urandom_range(0, 1)));
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; stop_i = 1'b0; pair_rdy_i = 1'b0; rot_done_i = 1'b0;
        test_reset();
        test_main();
        test_stall();
        test_stop();
        test_stop_last();
        test_stray();
        test_reset_mid_wait();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
